// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared encodings for the iterative RV32M multiply/divide unit:
//   - op encodings (funct3 of the M-extension instructions)
//   - FSM state encodings
//   - small decode helpers for operand signedness
package muldiv_unit_pkg;

  localparam int unsigned MD_OP_WIDTH    = 3;
  localparam int unsigned MD_STATE_WIDTH = 2;

  localparam logic [MD_OP_WIDTH-1:0] MD_MUL    = 3'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULH   = 3'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULHSU = 3'd2;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULHU  = 3'd3;
  localparam logic [MD_OP_WIDTH-1:0] MD_DIV    = 3'd4;
  localparam logic [MD_OP_WIDTH-1:0] MD_DIVU   = 3'd5;
  localparam logic [MD_OP_WIDTH-1:0] MD_REM    = 3'd6;
  localparam logic [MD_OP_WIDTH-1:0] MD_REMU   = 3'd7;

  localparam logic [MD_STATE_WIDTH-1:0] MD_IDLE = 2'd0;
  localparam logic [MD_STATE_WIDTH-1:0] MD_CALC = 2'd1;
  localparam logic [MD_STATE_WIDTH-1:0] MD_FIN  = 2'd2;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic md_a_signed(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM.
  function automatic logic md_b_signed(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_MUL) || (op == MD_MULH) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit. One operation takes XLEN+1 cycles
//   after the start edge; multiply is radix-2 shift-add, divide is restoring.
//   Both datapaths run on unsigned magnitudes and the sign is fixed up in FIN.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   operation request, sampled only while idle
//   flush  in   synchronous kill of any in-flight operation
//   op     in   funct3 operation select (MUL..REMU)
//   src_a  in   rs1 operand
//   src_b  in   rs2 operand
//   busy   out  operation in flight
//   done   out  one-cycle pulse, result valid
//   result out  registered result, held until the next done
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   flush,
  input  logic [MD_OP_WIDTH-1:0] op,
  input  logic [XLEN-1:0]        src_a,
  input  logic [XLEN-1:0]        src_b,
  output logic                   busy,
  output logic                   done,
  output logic [XLEN-1:0]        result
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic [MD_STATE_WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MD_OP_WIDTH-1:0]    op_q, op_d;
  logic                      sa_q, sa_d;       // rs1 negative (signed ops only)
  logic                      sb_q, sb_d;       // rs2 negative (signed ops only)
  logic                      bzero_q, bzero_d;
  logic [XLEN-1:0]           a_raw_q, a_raw_d; // unmodified rs1 for REM by zero
  logic [XLEN-1:0]           b_mag_q, b_mag_d;
  logic [2*XLEN-1:0]         prod_q, prod_d;
  logic [XLEN-1:0]           quo_q, quo_d;
  logic [XLEN-1:0]           rem_q, rem_d;
  logic [XLEN-1:0]           result_q, result_d;
  logic                      done_q, done_d;

  // Operand preparation at the start edge.
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_neg = md_a_signed(op) & src_a[XLEN-1];
  assign b_neg = md_b_signed(op) & src_b[XLEN-1];
  assign a_mag = mag(src_a, a_neg);
  assign b_mag = mag(src_b, b_neg);

  // Shift-add step: add the multiplicand into the upper half when the
  // multiplier LSB is set; the carry lands in the bit shifted back down.
  logic [XLEN:0] mul_sum;
  assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                   {1'b0, (prod_q[0] ? b_mag_q : {XLEN{1'b0}})};

  // Restoring step. The trial remainder is < 2*divisor, so the difference
  // is negative exactly when its top bit is set.
  logic [XLEN:0] div_trial, div_diff;
  logic          div_ge;
  assign div_trial = {rem_q, quo_q[XLEN-1]};
  assign div_diff  = div_trial - {1'b0, b_mag_q};
  assign div_ge    = ~div_diff[XLEN];

  // Sign-corrected final result, consumed in FIN.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_result;

  assign prod_fix = neg2(prod_q, sa_q ^ sb_q);
  assign quo_fix  = mag(quo_q, sa_q ^ sb_q);
  assign rem_fix  = mag(rem_q, sa_q);

  always_comb begin
    fin_result = '0;
    case (op_q)
      MD_MUL:                       fin_result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fin_result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fin_result = bzero_q ? '1 : quo_fix;
      MD_REM, MD_REMU:              fin_result = bzero_q ? a_raw_q : rem_fix;
      default:                      fin_result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bzero_d  = bzero_q;
    a_raw_d  = a_raw_q;
    b_mag_d  = b_mag_q;
    prod_d   = prod_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    done_d   = 1'b0;

    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            state_d = MD_CALC;
            cnt_d   = '0;
            op_d    = op;
            sa_d    = a_neg;
            sb_d    = b_neg;
            bzero_d = (src_b == '0);
            a_raw_d = src_a;
            b_mag_d = b_mag;
            prod_d  = {{XLEN{1'b0}}, a_mag};
            quo_d   = a_mag;
            rem_d   = '0;
          end
        end
        MD_CALC: begin
          // Both datapaths step every cycle so latency never depends on op.
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
          quo_d  = {quo_q[XLEN-2:0], div_ge};
          rem_d  = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = MD_FIN;
          end
        end
        MD_FIN: begin
          state_d  = MD_IDLE;
          result_d = fin_result;
          done_d   = 1'b1;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bzero_q  <= 1'b0;
      a_raw_q  <= '0;
      b_mag_q  <= '0;
      prod_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bzero_q  <= bzero_d;
      a_raw_q  <= a_raw_d;
      b_mag_q  <= b_mag_d;
      prod_q   <= prod_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != MD_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit (XLEN = 32). Expected results are pushed
//   when an operation is issued and popped when done is observed.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] last_exp = '0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model built on 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    r = '0;
    case (o)
      OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; r = p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      OP_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Called at a negedge; drives start for one edge, then scrambles operands.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input bit push);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Bounded wait for done; lat counts edges since the start edge.
  task automatic wait_done(input int base, output logic [31:0] obs, output int lat,
                           output bit ok);
    ok  = 1'b0;
    lat = 0;
    obs = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok  = 1'b1;
        lat = base + i;
        obs = result;
        break;
      end
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_mul;
    logic [31:0] e;
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mul_busy_k got %b want 1", busy); end
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== (i < LAT)) begin
        n_err++; $display("FAIL mul_busy_k+%0d got %b want %b", i, busy, (i < LAT));
      end
      n_cmp++;
      if (done !== (i == LAT)) begin
        n_err++; $display("FAIL mul_done_k+%0d got %b want %b", i, done, (i == LAT));
      end
    end
    e = sb.pop_front();
    n_cmp++; if (result !== e) begin n_err++; $display("FAIL mul_result got %h want %h", result, e); end
    last_exp = e;
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mul_done_width got %b want 0", done); end
  endtask

  task automatic test_mulh;
    logic [2:0]  o[3];
    logic [31:0] a[3], b[3], x[3];
    logic [31:0] obs, e;
    int lat; bit ok;
    o = '{OP_MULH, OP_MULHU, OP_MULHSU};
    a = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    b = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
    x = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    for (int t = 0; t < 3; t++) begin
      issue(o[t], a[t], b[t], x[t], 1'b1);
      wait_done(0, obs, lat, ok);
      e = sb.pop_front();
      n_cmp++; if (!ok || obs !== e) begin n_err++; $display("FAIL mulh_%0d got %h (done=%0d) want %h", t, obs, ok, e); end
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL mulh_%0d_latency got %0d want %0d", t, lat, LAT); end
      last_exp = e;
    end
  endtask

  task automatic test_div;
    logic [2:0]  o[4];
    logic [31:0] a[4], b[4], x[4];
    logic [31:0] obs, e;
    int lat; bit ok;
    o = '{OP_DIV, OP_REM, OP_DIV, OP_REM};
    a = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
    b = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    x = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    for (int t = 0; t < 4; t++) begin
      issue(o[t], a[t], b[t], x[t], 1'b1);
      wait_done(0, obs, lat, ok);
      e = sb.pop_front();
      n_cmp++; if (!ok || obs !== e) begin n_err++; $display("FAIL div_%0d got %h (done=%0d) want %h", t, obs, ok, e); end
      last_exp = e;
    end
  endtask

  task automatic test_divzero;
    logic [2:0]  o[4];
    logic [31:0] a[4], x[4];
    logic [31:0] obs, e;
    int lat; bit ok;
    o = '{OP_DIVU, OP_DIV, OP_REM, OP_REMU};
    a = '{32'd123, 32'hFFFF_FFFB, 32'd5, 32'hDEAD_BEEF};
    x = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hDEAD_BEEF};
    for (int t = 0; t < 4; t++) begin
      issue(o[t], a[t], 32'd0, x[t], 1'b1);
      wait_done(0, obs, lat, ok);
      e = sb.pop_front();
      n_cmp++; if (!ok || obs !== e) begin n_err++; $display("FAIL divzero_%0d got %h (done=%0d) want %h", t, obs, ok, e); end
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL divzero_%0d_latency got %0d want %0d", t, lat, LAT); end
      last_exp = e;
    end
  endtask

  task automatic test_ignored_start;
    logic [31:0] obs, e;
    int lat, n; bit ok;
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    repeat (9) @(negedge clk);
    op = OP_MUL; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(10, obs, lat, ok);
    e = sb.pop_front();
    n_cmp++; if (!ok || obs !== e) begin n_err++; $display("FAIL ignored_start_result got %h (done=%0d) want %h", obs, ok, e); end
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL ignored_start_latency got %0d want %0d", lat, LAT); end
    last_exp = e;
    count_dones(40, n);
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL ignored_start_extra_done got %0d want 0", n); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  o[5];
    logic [31:0] a[5], b[5];
    logic [31:0] obs, e;
    int lat; bit ok;
    for (int t = 0; t < 4; t++) begin
      o[t] = 3'($urandom_range(0, 7));
      a[t] = $urandom;
      b[t] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
    end
    o[4] = OP_MULHU; a[4] = 32'hFFFF_FFFF; b[4] = 32'hFFFF_FFFF;
    issue(o[0], a[0], b[0], ref_model(o[0], a[0], b[0]), 1'b1);
    for (int t = 0; t < 5; t++) begin
      wait_done(0, obs, lat, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || obs !== e) begin
        n_err++;
        $display("FAIL b2b_%0d op%0d a=%h b=%h got %h (done=%0d) want %h", t, o[t], a[t], b[t], obs, ok, e);
      end
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL b2b_%0d_latency got %0d want %0d", t, lat, LAT); end
      last_exp = e;
      if (t < 4) issue(o[t+1], a[t+1], b[t+1], ref_model(o[t+1], a[t+1], b[t+1]), 1'b1);
    end
  endtask

  task automatic test_flush;
    int n;
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL flush_done got %b want 0", done); end
    n_cmp++; if (result !== last_exp) begin n_err++; $display("FAIL flush_result got %h want %h", result, last_exp); end
    count_dones(40, n);
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL flush_late_done got %0d want 0", n); end
  endtask

  task automatic test_async_reset;
    logic [31:0] obs, e;
    int lat, n; bit ok;
    issue(OP_MUL, 32'd9, 32'd9, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL arst_done got %b want 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL arst_result got %h want 0", result); end
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_release_busy got %b want 0", busy); end
    count_dones(40, n);
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL arst_late_done got %0d want 0", n); end
    issue(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);
    wait_done(0, obs, lat, ok);
    e = sb.pop_front();
    n_cmp++; if (!ok || obs !== e) begin n_err++; $display("FAIL arst_recover got %h (done=%0d) want %h", obs, ok, e); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_divzero();
    test_ignored_start();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
